// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal shift register.
// Supports parallel load, logical/arithmetic/rotate shifts both ways and a
// synchronous clear. A saturating shift counter plus a one-cycle Done pulse
// let the block act as a serialiser/deserialiser.
// Optional build macro: USR_NEG_SHADOW_EN adds QnShadow_o, a copy of Q taken
// on every falling clock edge.
module univ_shift_reg #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int             CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             Clk_i,
  input  logic             Reset_i,
  input  logic             En_i,
  input  logic [2:0]       Mode_i,
  input  logic             SerIn_i,
  input  logic [WIDTH-1:0] D_i,
`ifdef USR_NEG_SHADOW_EN
  output logic [WIDTH-1:0] QnShadow_o,
`endif
  output logic [WIDTH-1:0] Q_o,
  output logic             SerOutL_o,
  output logic             SerOutR_o,
  output logic [CNT_W-1:0] ShiftCnt_o,
  output logic             Done_o
);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_LOAD  = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_SHR   = 3'b011,
    MODE_ROTL  = 3'b100,
    MODE_ROTR  = 3'b101,
    MODE_ASR   = 3'b110,
    MODE_CLEAR = 3'b111
  } mode_e;

  // Counter saturates at WIDTH; CNT_LAST is the value just before that.
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shift_op;
  mode_e            mode;

  assign mode = mode_e'(Mode_i);

  // Next-state decode for data register, shift counter and Done pulse.
  always_comb begin
    q_d      = q_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    shift_op = 1'b0;
    if (En_i) begin
      case (mode)
        MODE_HOLD: begin
          q_d = q_q;
        end
        MODE_LOAD: begin
          q_d   = D_i;
          cnt_d = '0;
        end
        MODE_SHL: begin
          q_d      = {q_q[WIDTH-2:0], SerIn_i};
          shift_op = 1'b1;
        end
        MODE_SHR: begin
          q_d      = {SerIn_i, q_q[WIDTH-1:1]};
          shift_op = 1'b1;
        end
        MODE_ROTL: begin
          q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          shift_op = 1'b1;
        end
        MODE_ROTR: begin
          q_d      = {q_q[0], q_q[WIDTH-1:1]};
          shift_op = 1'b1;
        end
        MODE_ASR: begin
          q_d      = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
          shift_op = 1'b1;
        end
        MODE_CLEAR: begin
          q_d   = '0;
          cnt_d = '0;
        end
        default: begin
          q_d = q_q;
        end
      endcase
    end
    // Shifts keep moving Q after saturation; only the count stops.
    if (shift_op) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      done_d = (cnt_q == CNT_LAST);
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      q_q    <= RESET_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

`ifdef USR_NEG_SHADOW_EN
  logic [WIDTH-1:0] shadow_q;

  // Half-cycle-late copy of Q. A reset sampled on the rising edge has already
  // forced Q to RESET_VAL, so the following falling edge picks it up.
  always_ff @(negedge Clk_i) begin
    shadow_q <= q_q;
  end

  assign QnShadow_o = shadow_q;
`endif

  assign Q_o        = q_q;
  assign SerOutL_o  = q_q[WIDTH-1];
  assign SerOutR_o  = q_q[0];
  assign ShiftCnt_o = cnt_q;
  assign Done_o     = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8, RESET_VAL=0).
// Build with USR_NEG_SHADOW_EN defined to also exercise QnShadow_o.
module tb_univ_shift_reg;

  localparam int W     = 8;
  localparam int CW    = $clog2(W + 1);
  localparam int MASK  = (1 << W) - 1;
  localparam int MSB   = 1 << (W - 1);

  logic          clk;
  logic          rst;
  logic          en;
  logic [2:0]    mode;
  logic          serin;
  logic [W-1:0]  d;
  logic [W-1:0]  q;
  logic          serl;
  logic          serr;
  logic [CW-1:0] cnt;
  logic          done;
`ifdef USR_NEG_SHADOW_EN
  logic [W-1:0]  qn_shadow;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model state
  int m_q    = 0;
  int m_cnt  = 0;
  int m_done = 0;

  univ_shift_reg #(.WIDTH(W), .RESET_VAL('0)) dut (
    .Clk_i      (clk),
    .Reset_i    (rst),
    .En_i       (en),
    .Mode_i     (mode),
    .SerIn_i    (serin),
    .D_i        (d),
`ifdef USR_NEG_SHADOW_EN
    .QnShadow_o (qn_shadow),
`endif
    .Q_o        (q),
    .SerOutL_o  (serl),
    .SerOutR_o  (serr),
    .ShiftCnt_o (cnt),
    .Done_o     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: plain integer arithmetic on the register value.
  task automatic model(input int r, input int e, input int md, input int s, input int dv);
    int prev;
    if (r != 0) begin
      m_q = 0; m_cnt = 0; m_done = 0;
    end else if (e == 0) begin
      m_done = 0;
    end else begin
      m_done = 0;
      if (md == 1) begin
        m_q = dv & MASK; m_cnt = 0;
      end else if (md == 7) begin
        m_q = 0; m_cnt = 0;
      end else if (md >= 2 && md <= 6) begin
        case (md)
          2: m_q = ((m_q * 2) + s) & MASK;
          3: m_q = (m_q / 2) + s * MSB;
          4: m_q = ((m_q * 2) & MASK) + (m_q / MSB);
          5: m_q = (m_q / 2) + (m_q % 2) * MSB;
          default: m_q = (m_q / 2) + (m_q & MSB);
        endcase
        prev  = m_cnt;
        m_cnt = (m_cnt + 1 > W) ? W : m_cnt + 1;
        m_done = (prev < W && m_cnt == W) ? 1 : 0;
      end
    end
  endtask

  // One clock: drive inputs, take the rising edge, compare everything 1ns later.
  task automatic apply(input logic r, input logic e, input logic [2:0] md,
                       input logic s, input logic [W-1:0] dv, input string tag);
    rst = r; en = e; mode = md; serin = s; d = dv;
    @(posedge clk);
    model(int'(r), int'(e), int'(md), int'(s), int'(dv));
    #1;
    chk({tag, ".q"},    32'(q),    32'(m_q));
    chk({tag, ".cnt"},  32'(cnt),  32'(m_cnt));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
    chk({tag, ".serl"}, 32'(serl), 32'((m_q / MSB) % 2));
    chk({tag, ".serr"}, 32'(serr), 32'(m_q % 2));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 3'd0; serin = 1'b0; d = '0;
    #2;

    // Reset for two edges
    apply(1'b1, 1'b0, 3'd0, 1'b0, 8'h00, "rst0");
    apply(1'b1, 1'b1, 3'd2, 1'b1, 8'hFF, "rst1");
    chk("rst.q_const", 32'(q), 32'h00);
    chk("rst.serl_const", 32'(serl), 32'h0);

    // Load then shl
    apply(1'b0, 1'b1, 3'd1, 1'b0, 8'hA5, "ldA5");
    chk("ldA5.serl_const", 32'(serl), 32'h1);
    apply(1'b0, 1'b1, 3'd2, 1'b1, 8'h00, "shl");
    chk("shl.q_const", 32'(q), 32'h4B);
    chk("shl.cnt_const", 32'(cnt), 32'h1);
    chk("shl.serl_const", 32'(serl), 32'h0);

    // Rotates and arithmetic shift
    apply(1'b0, 1'b1, 3'd1, 1'b0, 8'h81, "ld81");
    apply(1'b0, 1'b1, 3'd5, 1'b0, 8'h00, "rotr");
    chk("rotr.q_const", 32'(q), 32'hC0);
    apply(1'b0, 1'b1, 3'd4, 1'b0, 8'h00, "rotl");
    chk("rotl.q_const", 32'(q), 32'h81);
    apply(1'b0, 1'b1, 3'd1, 1'b0, 8'h80, "ld80");
    apply(1'b0, 1'b1, 3'd6, 1'b0, 8'h00, "asr80");
    chk("asr80.q_const", 32'(q), 32'hC0);
    apply(1'b0, 1'b1, 3'd1, 1'b0, 8'h40, "ld40");
    apply(1'b0, 1'b1, 3'd6, 1'b1, 8'h00, "asr40");
    chk("asr40.q_const", 32'(q), 32'h20);

    // Clear then 8 shr with SerIn=1, then a 9th
    apply(1'b0, 1'b1, 3'd7, 1'b0, 8'h00, "clr");
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 1'b1, 3'd3, 1'b1, 8'h00, $sformatf("shr%0d", i));
      if (i < 7) chk("shr.no_early_done", 32'(done), 32'h0);
    end
    chk("shr8.q_const", 32'(q), 32'hFF);
    chk("shr8.cnt_const", 32'(cnt), 32'd8);
    chk("shr8.done_const", 32'(done), 32'h1);
    apply(1'b0, 1'b1, 3'd3, 1'b1, 8'h00, "shr9");
    chk("shr9.cnt_const", 32'(cnt), 32'd8);
    chk("shr9.done_const", 32'(done), 32'h0);

    // En=0 stall for 3 cycles mid-sequence delays Done by 3
    apply(1'b0, 1'b1, 3'd7, 1'b0, 8'h00, "clr2");
    for (int i = 0; i < 4; i++) apply(1'b0, 1'b1, 3'd3, 1'b1, 8'h00, "stA");
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 3'd3, 1'b1, 8'h00, "stall");
      chk("stall.done_const", 32'(done), 32'h0);
      chk("stall.cnt_const", 32'(cnt), 32'd4);
    end
    for (int i = 0; i < 4; i++) apply(1'b0, 1'b1, 3'd3, 1'b1, 8'h00, "stB");
    chk("stall_end.done_const", 32'(done), 32'h1);

    // Reset mid-sequence: no Done pulse
    apply(1'b0, 1'b1, 3'd7, 1'b0, 8'h00, "clr3");
    for (int i = 0; i < 5; i++) apply(1'b0, 1'b1, 3'd2, 1'b1, 8'h00, "pre");
    apply(1'b1, 1'b1, 3'd2, 1'b1, 8'h00, "midrst");
    chk("midrst.q_const", 32'(q), 32'h00);
    chk("midrst.cnt_const", 32'(cnt), 32'd0);
    for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, 3'd2, 1'b1, 8'h00, "post");

`ifdef USR_NEG_SHADOW_EN
    // Shadow lags Q by half a cycle
    apply(1'b0, 1'b1, 3'd1, 1'b0, 8'h11, "ld11");
    @(negedge clk); #1;
    chk("shadow.pre", 32'(qn_shadow), 32'h11);
    apply(1'b0, 1'b1, 3'd1, 1'b0, 8'h3C, "ld3C");
    chk("shadow.old", 32'(qn_shadow), 32'h11);
    @(negedge clk); #1;
    chk("shadow.new", 32'(qn_shadow), 32'h3C);
`endif

    // Randomized operations against the model
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 31) == 0),
            ($urandom_range(0, 7) != 0),
            3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)),
            8'($urandom),
            "rnd");
    end

    // Long shift run from random data to hit saturation again
    apply(1'b0, 1'b1, 3'd1, 1'b0, 8'($urandom), "ldr");
    for (int i = 0; i < 12; i++)
      apply(1'b0, 1'b1, 3'($urandom_range(2, 6)), 1'($urandom_range(0, 1)), 8'h00, "sat");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal shift register. It generalises the team's single-bit D latch and master-slave flip-flop cells into a WIDTH-bit register with these operations:
- parallel load
- logical, arithmetic and rotate shifts in both directions
- synchronous clear

A saturating shift counter with a one-cycle Done pulse lets the block act as a serialiser/deserialiser in lab datapaths.

Parameters:
WIDTH, 8, register width in bits; legal range WIDTH >= 2.
RESET_VAL, 0, value loaded into Q on Reset; WIDTH bits.
CNT_W, $clog2(WIDTH+1), width of ShiftCnt; derived, never overridden.

Ports:
Clk  input  1  clock; all state updates on rising edge.
Reset  input  1  synchronous, active-high reset.
En  input  1  operation enable; when 0 all state holds.
Mode  input  3  operation select, decoded below.
SerIn  input  1  serial input bit for logical shifts.
D  input  WIDTH  parallel load data.
Q  output  WIDTH  register contents.
SerOutL  output  1  combinational, equals Q[WIDTH-1].
SerOutR  output  1  combinational, equals Q[0].
ShiftCnt  output  CNT_W  shifts since last load/clear; saturates at WIDTH.
Done  output  1  registered one-cycle pulse when ShiftCnt reaches WIDTH.
QnShadow  output  WIDTH  present only with USR_NEG_SHADOW_EN (see below).

Behaviour:
- Reset:
  - Reset=1 at a rising edge: Q=RESET_VAL, ShiftCnt=0, Done=0.
  - Reset overrides En and Mode.
  - Reset mid-sequence abandons the count with no Done pulse.
- En=0: Q and ShiftCnt hold; Done=0 on the next edge.
- Mode decode (En=1), applied at the rising edge:
  - 000 hold: Q unchanged; ShiftCnt unchanged.
  - 001 load: Q=D; ShiftCnt=0.
  - 010 shl: Q={Q[WIDTH-2:0],SerIn}.
  - 011 shr: Q={SerIn,Q[WIDTH-1:1]}.
  - 100 rotl: Q={Q[WIDTH-2:0],Q[WIDTH-1]}.
  - 101 rotr: Q={Q[0],Q[WIDTH-1:1]}.
  - 110 asr: Q={Q[WIDTH-1],Q[WIDTH-1:1]}; SerIn ignored.
  - 111 clear: Q=0; ShiftCnt=0.
- Shift counter: modes 010-110 with En=1 increment ShiftCnt by 1, saturating at WIDTH. Once saturated, further shifts still move Q.
- Done:
  - Done=1 for exactly the one cycle following the edge where ShiftCnt goes WIDTH-1 -> WIDTH.
  - Otherwise 0, including every cycle while saturated.
- Latency: Q, ShiftCnt and Done are valid 1 cycle after the edge that samples the inputs. SerOutL/SerOutR follow Q combinationally with no added latency.
- Load and shift are mutually exclusive by Mode encoding; no simultaneous-event priority beyond Reset > En > Mode.
- No latches inferred; all state is in edge-triggered registers.

Optional Feature:
Macro USR_NEG_SHADOW_EN.
- Defined:
  - Port QnShadow exists; it is a WIDTH-bit register that captures Q on every falling edge of Clk.
  - QnShadow therefore lags Q by half a cycle.
  - Synchronous Reset also clears QnShadow to RESET_VAL at the falling edge following a rising edge that sampled Reset=1.
- Not defined: port QnShadow and its register are absent; all other behaviour is identical.

Test Plan:
Test configuration: WIDTH=8, RESET_VAL=0.
- Reset=1 for 2 edges -> Q=0x00, ShiftCnt=0, Done=0; SerOutL=SerOutR=0.
- Load 0xA5, then shl with SerIn=1 -> Q=0x4B, ShiftCnt=1; SerOutL was 1 before the shift, 0 after.
- Load 0x81: rotr -> Q=0xC0; then rotl -> Q=0x81. Load 0x80: asr -> Q=0xC0. Load 0x40: asr -> Q=0x20.
- Clear, then 8 consecutive shr with SerIn=1 and En=1 -> Q=0xFF, ShiftCnt=8.
  - Done=1 only in the cycle after the 8th edge.
  - A 9th shr keeps ShiftCnt=8 with Done=0.
  - En=0 for 3 cycles inserted mid-sequence delays Done by exactly 3 cycles.
- After 5 shifts, assert Reset with En=1, Mode=010 -> next edge Q=0x00, ShiftCnt=0, and no Done pulse.
- With USR_NEG_SHADOW_EN, load 0x3C -> QnShadow keeps its old value until the next falling edge, then becomes 0x3C. Without the macro the bench compiles with no QnShadow port.
